// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: address/data handshake bundle shared by the two requesters
// and the downstream port of dbus_arbiter.
// master drives the request fields; slave answers with addr_ok/data_ok/rdata.
interface dbus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [2:0]            size;
  logic [DATA_W/8-1:0]   strobe;
  logic [DATA_W-1:0]     data;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output valid, addr, size, strobe, data,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  valid, addr, size, strobe, data,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares one downstream data-bus port between the memory stage
// (m_bus) and the instruction fetch stage (f_bus), one transaction at a time.
// Optional macro DBUS_ARB_ROUND_ROBIN_EN: alternate the winner on ties using
// a last_owner register (resets to F so M wins the first tie). Undefined:
// fixed priority, M over F.
module dbus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  dbus_arbiter_if.slave        m_bus,
  dbus_arbiter_if.slave        f_bus,
  dbus_arbiter_if.master       d_bus,
  output logic                 busy
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
  typedef enum logic {OWN_M = 1'b0, OWN_F = 1'b1} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [STRB_W-1:0]   strobe_q, strobe_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic grant_m;
  logic grant_f;
  logic resp_ok;

`ifdef DBUS_ARB_ROUND_ROBIN_EN
  owner_t last_owner_q, last_owner_d;
`endif

  // Pick the winner in IDLE; resetn gating keeps addr_ok low while in reset.
  always_comb begin
    grant_m = 1'b0;
    grant_f = 1'b0;
    if (state_q == IDLE && resetn) begin
`ifdef DBUS_ARB_ROUND_ROBIN_EN
      if (m_bus.valid && f_bus.valid) begin
        grant_m = (last_owner_q == OWN_F);
        grant_f = (last_owner_q == OWN_M);
      end else begin
        grant_m = m_bus.valid;
        grant_f = f_bus.valid;
      end
`else
      grant_m = m_bus.valid;
      grant_f = f_bus.valid && !m_bus.valid;
`endif
    end
  end

  // Next-state, request buffer capture and response detection.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    resp_ok  = 1'b0;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_m) begin
          state_d  = ADDR;
          owner_d  = OWN_M;
          addr_d   = m_bus.addr;
          size_d   = m_bus.size;
          strobe_d = m_bus.strobe;
          data_d   = m_bus.data;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
          last_owner_d = OWN_M;
`endif
        end else if (grant_f) begin
          state_d  = ADDR;
          owner_d  = OWN_F;
          addr_d   = f_bus.addr;
          size_d   = f_bus.size;
          strobe_d = f_bus.strobe;
          data_d   = f_bus.data;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
          last_owner_d = OWN_F;
`endif
        end
      end
      ADDR: begin
        // data_ok without addr_ok here is a protocol error and is ignored.
        if (d_bus.addr_ok) begin
          if (d_bus.data_ok) begin
            resp_ok = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (d_bus.data_ok) begin
          resp_ok = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request buffer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= OWN_M;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      data_q   <= '0;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_F;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
`ifdef DBUS_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign m_bus.addr_ok = grant_m;
  assign f_bus.addr_ok = grant_f;
  assign m_bus.data_ok = resp_ok && (owner_q == OWN_M);
  assign f_bus.data_ok = resp_ok && (owner_q == OWN_F);
  assign m_bus.rdata   = m_bus.data_ok ? d_bus.rdata : '0;
  assign f_bus.rdata   = f_bus.data_ok ? d_bus.rdata : '0;

  assign d_bus.valid   = (state_q == ADDR);
  assign d_bus.addr    = addr_q;
  assign d_bus.size    = size_q;
  assign d_bus.strobe  = strobe_q;
  assign d_bus.data    = data_q;

  assign busy          = (state_q != IDLE);
endmodule
